reg_file_scoreboard: RTL and testbench
======================================

REG_FILE_SCOREBOARD -- requirements
Module: reg_file_scoreboard

Interface
REQ-001 SHALL provide parameter DATA_W, default 32, register data width in bits.
REQ-002 SHALL provide parameter ADDR_W, default 5, register address width; depth NUM_REGS = 2**ADDR_W.
REQ-003 SHALL provide parameter ZERO_REG, default 1, where 1 hardwires entry 0 to zero.
REQ-004 SHALL have port sys_clk  input  1  single clock; all state changes on rising edge.
REQ-005 SHALL have port sys_reset  input  1  reset, synchronous and active-high.
REQ-006 SHALL have ports rs_addr_i, rt_addr_i  input  ADDR_W  read port A/B addresses.
REQ-007 SHALL have ports rs_data_o, rt_data_o  output  DATA_W  read port A/B data.
REQ-008 SHALL have ports rs_busy_o, rt_busy_o  output  1  pending-write flag for rs/rt address.
REQ-009 SHALL have ports wr_en_i 1, wr_addr_i ADDR_W, wr_data_i DATA_W, all input: write port.
REQ-010 SHALL have ports claim_en_i 1, claim_addr_i ADDR_W, both input: marks destination pending.
REQ-011 SHALL have port dbg_addr_i  input  ADDR_W, and dbg_data_o  output  DATA_W, debug read (no bypass).
REQ-012 SHALL have port ready_o  output  1  high once post-reset clear has finished.

Function
REQ-013 SHALL implement a two-state FSM: CLEAR, READY; reset enters CLEAR with clear index 0.
REQ-014 SHALL, in CLEAR, write 0 to entry[index] each cycle, index+1 each cycle; after index NUM_REGS-1 go to READY next cycle (NUM_REGS cycles in CLEAR).
REQ-015 SHALL hold ready_o low in CLEAR, high in READY.
REQ-016 SHALL, in CLEAR, ignore wr_en_i and claim_en_i and drive rs/rt/dbg data 0 and busy 0.
REQ-017 SHALL, in READY, write wr_data_i to entry[wr_addr_i] on the rising edge when wr_en_i=1.
REQ-018 SHALL read all ports combinationally (zero cycle latency) from the array.
REQ-019 SHALL bypass: when wr_en_i=1 and wr_addr_i equals rs_addr_i (resp. rt_addr_i), rs_data_o (rt_data_o) equals wr_data_i in the same cycle.
REQ-020 SHALL NOT bypass dbg_data_o; it shows stored contents only.
REQ-021 SHALL, with ZERO_REG=1, ignore writes and claims to address 0 and return 0 and busy 0 for address 0 on all ports.
REQ-022 SHALL keep one busy bit per entry: claim_en_i sets busy[claim_addr_i] next edge; wr_en_i clears busy[wr_addr_i] next edge.
REQ-023 SHALL, on simultaneous claim and write to same address, leave busy set (claim wins); data still written.
REQ-024 SHALL drive rs_busy_o = busy[rs_addr_i] AND NOT (wr_en_i AND wr_addr_i==rs_addr_i); same rule for rt_busy_o.
REQ-025 SHALL allow claim and write to different addresses in the same cycle, both taking effect.
REQ-026 SHALL treat all addresses as unsigned; no out-of-range case exists since depth is 2**ADDR_W.

Reset
REQ-027 SHALL, on any edge with sys_reset=1, clear all busy bits, set ready_o=0, enter CLEAR with index 0, regardless of current state (mid-clear reset restarts clear).
REQ-028 SHALL, during and after reset, present rs/rt/dbg data 0, busy 0, ready_o 0 until CLEAR completes.
REQ-029 SHALL have every entry equal 0 on first READY cycle.

Verification
REQ-030 Reset 1 cycle, defaults -> ready_o low exactly 32 cycles, then high; dbg read of all 32 entries = 0.
REQ-031 READY, write addr 5 = 0xDEADBEEF with rs_addr_i=5 same cycle -> rs_data_o=0xDEADBEEF same cycle, dbg_data_o(5) old 0 that cycle, 0xDEADBEEF next.
REQ-032 Write addr 0 = 0x12345678, claim addr 0 -> rs_data_o(0)=0, rs_busy_o(0)=0 all cycles.
REQ-033 Claim addr 7; next cycle rt_busy_o=1; write addr 7 = 0xA5A5A5A5 -> rt_busy_o=0 that cycle (bypass), busy bit clear next cycle.
REQ-034 Claim and write addr 9 same cycle -> busy[9]=1 next cycle, entry 9 holds written data.
REQ-035 Assert sys_reset at clear index 10, and again after write in READY -> clear restarts at 0, ready_o low 32 more cycles, all entries and busy 0 afterward.

Source files
------------

// File: rtl/reg_file_scoreboard.sv
// rtl/reg_file_scoreboard.sv - register file with per-entry pending-write scoreboard and post-reset clear
//
// Ports:
//   sys_clk, sys_reset         clock, synchronous active-high reset
//   rs_addr_i/rs_data_o/rs_busy_o  read port A (write-bypassed) and its pending flag
//   rt_addr_i/rt_data_o/rt_busy_o  read port B (write-bypassed) and its pending flag
//   wr_en_i/wr_addr_i/wr_data_i    write port; a write also retires the pending flag
//   claim_en_i/claim_addr_i        marks a destination entry as pending
//   dbg_addr_i/dbg_data_o          debug read of stored contents, no bypass
//   ready_o                        high once every entry has been cleared after reset
module reg_file_scoreboard #(
   parameter int DATA_W   = 32,
   parameter int ADDR_W   = 5,
   parameter int ZERO_REG = 1
) (
   input  logic              sys_clk,
   input  logic              sys_reset,
   input  logic [ADDR_W-1:0] rs_addr_i,
   input  logic [ADDR_W-1:0] rt_addr_i,
   output logic [DATA_W-1:0] rs_data_o,
   output logic [DATA_W-1:0] rt_data_o,
   output logic              rs_busy_o,
   output logic              rt_busy_o,
   input  logic              wr_en_i,
   input  logic [ADDR_W-1:0] wr_addr_i,
   input  logic [DATA_W-1:0] wr_data_i,
   input  logic              claim_en_i,
   input  logic [ADDR_W-1:0] claim_addr_i,
   input  logic [ADDR_W-1:0] dbg_addr_i,
   output logic [DATA_W-1:0] dbg_data_o,
   output logic              ready_o
);

   localparam int NUM_REGS = 1 << ADDR_W;

   typedef enum logic {ST_CLEAR = 1'b0, ST_READY = 1'b1} state_t;

   state_t              state_q;
   state_t              state_d;
   logic [ADDR_W-1:0]   clr_idx_q;
   logic [DATA_W-1:0]   mem [NUM_REGS];
   logic [NUM_REGS-1:0] busy_q;

   logic ready_int;
   logic wr_ok;
   logic claim_ok;
   logic rs_zero, rt_zero, dbg_zero;
   logic rs_hit, rt_hit;

   // State register
   always_ff @(posedge sys_clk) begin
      if (sys_reset) begin
         state_q   <= ST_CLEAR;
         clr_idx_q <= '0;
      end else begin
         state_q <= state_d;
         if (state_q == ST_CLEAR) begin
            clr_idx_q <= clr_idx_q + ADDR_W'(1);
         end
      end
   end

   // Next-state logic: leave CLEAR after the last index has been written
   always_comb begin
      state_d = state_q;
      if (state_q == ST_CLEAR && (&clr_idx_q)) begin
         state_d = ST_READY;
      end
   end

   // Output / control logic. Gating with sys_reset keeps every output quiet
   // in the reset cycle itself, before the state register has been forced.
   always_comb begin
      ready_int = (state_q == ST_READY) && !sys_reset;
      rs_zero   = (ZERO_REG != 0) && (rs_addr_i  == '0);
      rt_zero   = (ZERO_REG != 0) && (rt_addr_i  == '0);
      dbg_zero  = (ZERO_REG != 0) && (dbg_addr_i == '0);
      wr_ok     = ready_int && wr_en_i
                  && !((ZERO_REG != 0) && (wr_addr_i == '0));
      claim_ok  = ready_int && claim_en_i
                  && !((ZERO_REG != 0) && (claim_addr_i == '0));
      rs_hit    = wr_ok && (wr_addr_i == rs_addr_i);
      rt_hit    = wr_ok && (wr_addr_i == rt_addr_i);

      ready_o    = ready_int;
      rs_data_o  = '0;
      rt_data_o  = '0;
      dbg_data_o = '0;
      rs_busy_o  = 1'b0;
      rt_busy_o  = 1'b0;
      if (ready_int) begin
         if (!rs_zero) begin
            rs_data_o = rs_hit ? wr_data_i : mem[rs_addr_i];
            rs_busy_o = busy_q[rs_addr_i] && !rs_hit;
         end
         if (!rt_zero) begin
            rt_data_o = rt_hit ? wr_data_i : mem[rt_addr_i];
            rt_busy_o = busy_q[rt_addr_i] && !rt_hit;
         end
         if (!dbg_zero) begin
            dbg_data_o = mem[dbg_addr_i];
         end
      end
   end

   // Storage array: cleared one entry per cycle in CLEAR, written in READY
   always_ff @(posedge sys_clk) begin
      if (!sys_reset) begin
         if (state_q == ST_CLEAR) begin
            mem[clr_idx_q] <= '0;
         end else if (wr_ok) begin
            mem[wr_addr_i] <= wr_data_i;
         end
      end
   end

   // Scoreboard: the claim assignment comes last so it wins on a same-address collision
   always_ff @(posedge sys_clk) begin
      if (sys_reset) begin
         busy_q <= '0;
      end else begin
         if (wr_ok) begin
            busy_q[wr_addr_i] <= 1'b0;
         end
         if (claim_ok) begin
            busy_q[claim_addr_i] <= 1'b1;
         end
      end
   end

endmodule

// File: tb/tb_reg_file_scoreboard.sv
// tb/tb_reg_file_scoreboard.sv - directed self-checking bench for reg_file_scoreboard
module tb_reg_file_scoreboard;

   logic        sys_clk;
   logic        sys_reset;
   logic [4:0]  rs_addr_i, rt_addr_i, wr_addr_i, claim_addr_i, dbg_addr_i;
   logic [31:0] rs_data_o, rt_data_o, wr_data_i, dbg_data_o;
   logic        rs_busy_o, rt_busy_o, wr_en_i, claim_en_i, ready_o;

   int checks = 0;
   int errors = 0;

   reg_file_scoreboard dut (
      .sys_clk      (sys_clk),
      .sys_reset    (sys_reset),
      .rs_addr_i    (rs_addr_i),
      .rt_addr_i    (rt_addr_i),
      .rs_data_o    (rs_data_o),
      .rt_data_o    (rt_data_o),
      .rs_busy_o    (rs_busy_o),
      .rt_busy_o    (rt_busy_o),
      .wr_en_i      (wr_en_i),
      .wr_addr_i    (wr_addr_i),
      .wr_data_i    (wr_data_i),
      .claim_en_i   (claim_en_i),
      .claim_addr_i (claim_addr_i),
      .dbg_addr_i   (dbg_addr_i),
      .dbg_data_o   (dbg_data_o),
      .ready_o      (ready_o)
   );

   initial sys_clk = 1'b0;
   always #5 sys_clk = ~sys_clk;

   task automatic idle_inputs();
      wr_en_i      = 1'b0;
      wr_addr_i    = '0;
      wr_data_i    = '0;
      claim_en_i   = 1'b0;
      claim_addr_i = '0;
   endtask

   // Counts negedge samples with ready_o low until it rises (bounded)
   task automatic count_clear(output int lows);
      lows = 0;
      #1;
      while (!ready_o && lows < 100) begin
         lows++;
         @(negedge sys_clk);
         #1;
      end
   endtask

   task automatic test_reset();
      int lows;
      sys_reset = 1'b1;
      idle_inputs();
      rs_addr_i = 5'd3; rt_addr_i = 5'd4; dbg_addr_i = 5'd3;
      @(negedge sys_clk);
      @(negedge sys_clk);
      #1;
      checks++;
      if (ready_o !== 1'b0) begin
         errors++; $display("FAIL reset_ready: got %b expected 0", ready_o);
      end
      sys_reset = 1'b0;
      // write/claim attempts during CLEAR must be ignored and outputs stay 0
      wr_en_i = 1'b1; wr_addr_i = 5'd3; wr_data_i = 32'hFFFF_FFFF;
      claim_en_i = 1'b1; claim_addr_i = 5'd4;
      #1;
      checks++;
      if (rs_data_o !== 32'h0 || rs_busy_o !== 1'b0 || dbg_data_o !== 32'h0) begin
         errors++; $display("FAIL clear_outputs: got rs=%h busy=%b dbg=%h expected 0 0 0",
                            rs_data_o, rs_busy_o, dbg_data_o);
      end
      count_clear(lows);
      checks++;
      if (lows !== 32) begin
         errors++; $display("FAIL clear_length: got %0d expected 32", lows);
      end
      idle_inputs();
      for (int i = 0; i < 32; i++) begin
         dbg_addr_i = 5'(i); rs_addr_i = 5'(i); rt_addr_i = 5'(i);
         #1;
         checks++;
         if (dbg_data_o !== 32'h0 || rs_busy_o !== 1'b0 || rt_busy_o !== 1'b0) begin
            errors++; $display("FAIL reset_entry%0d: got dbg=%h busy=%b/%b expected 0 0/0",
                               i, dbg_data_o, rs_busy_o, rt_busy_o);
         end
      end
   endtask

   task automatic test_bypass();
      @(negedge sys_clk);
      wr_en_i = 1'b1; wr_addr_i = 5'd5; wr_data_i = 32'hDEAD_BEEF;
      rs_addr_i = 5'd5; rt_addr_i = 5'd5; dbg_addr_i = 5'd5;
      #1;
      checks++;
      if (rs_data_o !== 32'hDEAD_BEEF || rt_data_o !== 32'hDEAD_BEEF) begin
         errors++; $display("FAIL bypass_same_cycle: got rs=%h rt=%h expected deadbeef",
                            rs_data_o, rt_data_o);
      end
      checks++;
      if (dbg_data_o !== 32'h0) begin
         errors++; $display("FAIL dbg_no_bypass: got %h expected 0", dbg_data_o);
      end
      @(negedge sys_clk);
      idle_inputs();
      #1;
      checks++;
      if (dbg_data_o !== 32'hDEAD_BEEF || rs_data_o !== 32'hDEAD_BEEF) begin
         errors++; $display("FAIL write_stored: got dbg=%h rs=%h expected deadbeef",
                            dbg_data_o, rs_data_o);
      end
   endtask

   task automatic test_zero_reg();
      @(negedge sys_clk);
      wr_en_i = 1'b1; wr_addr_i = 5'd0; wr_data_i = 32'h1234_5678;
      claim_en_i = 1'b1; claim_addr_i = 5'd0;
      rs_addr_i = 5'd0; rt_addr_i = 5'd0; dbg_addr_i = 5'd0;
      #1;
      checks++;
      if (rs_data_o !== 32'h0 || rt_data_o !== 32'h0 || rs_busy_o !== 1'b0) begin
         errors++; $display("FAIL zero_write_cycle: got rs=%h rt=%h busy=%b expected 0 0 0",
                            rs_data_o, rt_data_o, rs_busy_o);
      end
      for (int c = 0; c < 2; c++) begin
         @(negedge sys_clk);
         idle_inputs();
         #1;
         checks++;
         if (rs_data_o !== 32'h0 || rs_busy_o !== 1'b0 || dbg_data_o !== 32'h0) begin
            errors++; $display("FAIL zero_after_%0d: got rs=%h busy=%b dbg=%h expected 0 0 0",
                               c, rs_data_o, rs_busy_o, dbg_data_o);
         end
      end
   endtask

   task automatic test_claim_then_write();
      @(negedge sys_clk);
      claim_en_i = 1'b1; claim_addr_i = 5'd7;
      rs_addr_i = 5'd7; rt_addr_i = 5'd7;
      #1;
      checks++;
      if (rt_busy_o !== 1'b0) begin
         errors++; $display("FAIL claim_not_yet: got %b expected 0", rt_busy_o);
      end
      @(negedge sys_clk);
      idle_inputs();
      #1;
      checks++;
      if (rt_busy_o !== 1'b1 || rs_busy_o !== 1'b1) begin
         errors++; $display("FAIL claim_busy: got rt=%b rs=%b expected 1 1", rt_busy_o, rs_busy_o);
      end
      @(negedge sys_clk);
      wr_en_i = 1'b1; wr_addr_i = 5'd7; wr_data_i = 32'hA5A5_A5A5;
      #1;
      checks++;
      if (rt_busy_o !== 1'b0 || rt_data_o !== 32'hA5A5_A5A5) begin
         errors++; $display("FAIL busy_bypass: got busy=%b data=%h expected 0 a5a5a5a5",
                            rt_busy_o, rt_data_o);
      end
      @(negedge sys_clk);
      idle_inputs();
      #1;
      checks++;
      if (rt_busy_o !== 1'b0 || rt_data_o !== 32'hA5A5_A5A5) begin
         errors++; $display("FAIL busy_retired: got busy=%b data=%h expected 0 a5a5a5a5",
                            rt_busy_o, rt_data_o);
      end
   endtask

   task automatic test_claim_write_same();
      @(negedge sys_clk);
      claim_en_i = 1'b1; claim_addr_i = 5'd9;
      wr_en_i = 1'b1; wr_addr_i = 5'd9; wr_data_i = 32'h0BAD_F00D;
      rs_addr_i = 5'd9; dbg_addr_i = 5'd9;
      @(negedge sys_clk);
      idle_inputs();
      #1;
      checks++;
      if (rs_busy_o !== 1'b1) begin
         errors++; $display("FAIL claim_wins: got %b expected 1", rs_busy_o);
      end
      checks++;
      if (dbg_data_o !== 32'h0BAD_F00D) begin
         errors++; $display("FAIL collide_data: got %h expected 0badf00d", dbg_data_o);
      end
   endtask

   task automatic test_back_to_back();
      @(negedge sys_clk);
      claim_en_i = 1'b1; claim_addr_i = 5'd11;
      wr_en_i = 1'b1; wr_addr_i = 5'd12; wr_data_i = 32'h5555_AAAA;
      @(negedge sys_clk);
      idle_inputs();
      rs_addr_i = 5'd11; rt_addr_i = 5'd12;
      #1;
      checks++;
      if (rs_busy_o !== 1'b1 || rt_busy_o !== 1'b0 || rt_data_o !== 32'h5555_AAAA) begin
         errors++; $display("FAIL split_claim_write: got busy11=%b busy12=%b data12=%h expected 1 0 5555aaaa",
                            rs_busy_o, rt_busy_o, rt_data_o);
      end
   endtask

   task automatic test_reset_restart();
      int lows;
      // restart the clear when it is at index 10
      @(negedge sys_clk);
      sys_reset = 1'b1;
      @(negedge sys_clk);
      sys_reset = 1'b0;
      repeat (10) @(negedge sys_clk);
      sys_reset = 1'b1;
      @(negedge sys_clk);
      sys_reset = 1'b0;
      count_clear(lows);
      checks++;
      if (lows !== 32) begin
         errors++; $display("FAIL midclear_restart: got %0d expected 32", lows);
      end
      // write then claim in READY, then reset again
      @(negedge sys_clk);
      wr_en_i = 1'b1; wr_addr_i = 5'd20; wr_data_i = 32'hCAFE_0020;
      claim_en_i = 1'b1; claim_addr_i = 5'd21;
      @(negedge sys_clk);
      idle_inputs();
      rs_addr_i = 5'd20; rt_addr_i = 5'd21; dbg_addr_i = 5'd20;
      #1;
      checks++;
      if (rs_data_o !== 32'hCAFE_0020 || rt_busy_o !== 1'b1) begin
         errors++; $display("FAIL pre_reset_state: got data=%h busy=%b expected cafe0020 1",
                            rs_data_o, rt_busy_o);
      end
      sys_reset = 1'b1;
      #1;
      checks++;
      if (rs_data_o !== 32'h0 || dbg_data_o !== 32'h0 || rt_busy_o !== 1'b0 || ready_o !== 1'b0) begin
         errors++; $display("FAIL during_reset: got rs=%h dbg=%h busy=%b ready=%b expected 0 0 0 0",
                            rs_data_o, dbg_data_o, rt_busy_o, ready_o);
      end
      @(negedge sys_clk);
      sys_reset = 1'b0;
      count_clear(lows);
      checks++;
      if (lows !== 32) begin
         errors++; $display("FAIL ready_restart: got %0d expected 32", lows);
      end
      for (int i = 0; i < 32; i++) begin
         dbg_addr_i = 5'(i); rs_addr_i = 5'(i);
         #1;
         checks++;
         if (dbg_data_o !== 32'h0 || rs_busy_o !== 1'b0) begin
            errors++; $display("FAIL restart_entry%0d: got dbg=%h busy=%b expected 0 0",
                               i, dbg_data_o, rs_busy_o);
         end
      end
   endtask

   initial begin
      test_reset();
      test_bypass();
      test_zero_reg();
      test_claim_then_write();
      test_claim_write_same();
      test_back_to_back();
      test_reset_restart();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
